// File: rtl/alu_exec_unit.sv
// Multi-cycle RV32 execute unit with a valid/ready handshake on both sides.
// Shifts step one bit per cycle unless BARREL_SHIFT_EN is defined, in which case every op takes one cycle.
//
// state | meaning
// IDLE  | ready for an op; accepts on in_valid
// SHIFT | iterative shift in progress (not built with BARREL_SHIFT_EN)
// DONE  | result/zero valid, held until out_ready
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifndef BARREL_SHIFT_EN
    SHIFT = 2'd1,
`endif
    DONE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic            is_shift;
  logic [SW-1:0]   amt;
  logic [WIDTH-1:0] alu_val;

  assign accept   = in_valid && in_ready;
  assign amt      = op_b[SW-1:0];
  assign is_shift = (alu_ctrl == 4'b0101) || (alu_ctrl == 4'b0110) || (alu_ctrl == 4'b0111);

  always_comb begin
    alu_val = op_a + op_b;
    case (alu_ctrl)
      4'b0001: alu_val = op_a - op_b;
      4'b0010: alu_val = op_a & op_b;
      4'b0011: alu_val = op_a | op_b;
      4'b0100: alu_val = op_a ^ op_b;
`ifdef BARREL_SHIFT_EN
      4'b0101: alu_val = op_a << amt;
      4'b0110: alu_val = op_a >> amt;
      4'b0111: alu_val = WIDTH'($signed(op_a) >>> amt);
`else
      // only reached with a zero amount; nonzero amounts go through SHIFT
      4'b0101, 4'b0110, 4'b0111: alu_val = op_a;
`endif
      4'b1000: alu_val = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'b1001: alu_val = {{(WIDTH-1){1'b0}}, op_a < op_b};
      default: alu_val = op_a + op_b;
    endcase
  end

`ifndef BARREL_SHIFT_EN
  logic [SW-1:0]    cnt;
  logic [1:0]       sh_op;
  logic [WIDTH-1:0] step;
  logic             last_step;

  assign last_step = (cnt == SW'(1));

  always_comb begin
    case (sh_op)
      2'b01:   step = {result[WIDTH-2:0], 1'b0};
      2'b10:   step = {1'b0, result[WIDTH-1:1]};
      default: step = {result[WIDTH-1], result[WIDTH-1:1]};
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifndef BARREL_SHIFT_EN
          if (is_shift && (amt != '0)) state_nxt = SHIFT;
          else
`endif
          state_nxt = DONE;
        end
      end
`ifndef BARREL_SHIFT_EN
      SHIFT: if (last_step) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // result doubles as the working register while shifting
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b0;
`ifndef BARREL_SHIFT_EN
      cnt    <= '0;
      sh_op  <= 2'b00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
`ifndef BARREL_SHIFT_EN
            if (is_shift && (amt != '0)) begin
              result <= op_a;
              cnt    <= amt;
              sh_op  <= alu_ctrl[1:0];
            end else
`endif
            begin
              result <= alu_val;
              zero   <= (alu_val == '0);
            end
          end
        end
`ifndef BARREL_SHIFT_EN
        SHIFT: begin
          result <= step;
          cnt    <= cnt - SW'(1);
          if (last_step) zero <= (step == '0);
        end
`endif
        default: ;
      endcase
    end
  end

  logic unused_is_shift;
  assign unused_is_shift = is_shift;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random ops against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = 4'h0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int k;
    logic [31:0] ones;
    k = int'(b % 32);
    ones = '1;
    case (c)
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << k;
      4'd6: return a >> k;
      4'd7: return a[31] ? ((a >> k) | ~(ones >> k)) : (a >> k);
      4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef BARREL_SHIFT_EN
    return 1;
`else
    int k;
    k = int'(b % 32);
    if ((c >= 4'd5) && (c <= 4'd7) && (k != 0)) return k + 1;
    return 1;
`endif
  endfunction

  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit early);
    logic [31:0] exp;
    int lat;
    exp = model_res(c, a, b);
    @(negedge clk);
    chk("idle_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
    out_ready = early;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    chk("latency", 64'(lat), 64'(model_lat(c, b)));
    chk("result", 64'(result), 64'(exp));
    chk("zero", 64'(zero), 64'(exp == 32'd0));
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_result", 64'(result), 64'(exp));
        chk("hold_flags", 64'({out_valid, in_ready}), 64'(2'b10));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("after_handshake", 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_flags", 64'({in_ready, out_valid}), 64'(2'b10));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));

    do_op(4'h0, 32'd5, 32'd7, 0, 1'b0);
    do_op(4'h1, 32'h10, 32'h10, 0, 1'b0);
    do_op(4'h8, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_op(4'h9, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_op(4'hF, 32'd3, 32'd4, 0, 1'b0);
    do_op(4'h7, 32'h8000_0000, 32'd4, 3, 1'b0);
    do_op(4'h6, 32'h8000_0000, 32'd4, 0, 1'b1);
    do_op(4'h5, 32'd1, 32'd31, 0, 1'b0);
    do_op(4'h5, 32'h0000_ABCD, 32'h20, 0, 1'b0);

    // second request waits behind a stalled result
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'h0; op_a = 32'd1; op_b = 32'd2;
    @(posedge clk); #1;
    op_a = 32'd10; op_b = 32'd20;
    @(negedge clk);
    chk("busy_first", 64'({out_valid, result}), 64'({1'b1, 32'd3}));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_hold", 64'({out_valid, in_ready, result}), 64'({2'b10, 32'd3}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("busy_gap", 64'({out_valid, in_ready}), 64'(2'b01));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("busy_second", 64'({out_valid, result}), 64'({1'b1, 32'd30}));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // reset in the middle of a 20-step shift
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'h5; op_a = 32'd3; op_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_flags", 64'({in_ready, out_valid}), 64'(2'b10));
    chk("midrst_result", 64'({zero, result}), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale", 64'(seen), 64'(0));

    for (int n = 0; n < 150; n++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      do_op(c, a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle integer execute unit for the RV32 datapath. It sits directly downstream of the ALU control decoder and consumes the decoder's 4-bit ALU operation code together with two operands. It returns a registered result and a zero flag through a valid/ready handshake. Shifts run iteratively, one bit per cycle, unless the barrel-shifter option is compiled in; all other operations complete in one cycle.

## Interface
- WIDTH, 32, operand/result width; must be a power of two ≥ 8
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept an operation (high only in IDLE)
- alu_ctrl  input  4  operation code: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU
- op_a  input  WIDTH  first operand (shift source)
- op_b  input  WIDTH  second operand; shift amount is op_b[log2(WIDTH)-1:0]
- out_valid  output  1  result and zero are valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  registered flag, result == 0

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Accept when in_valid && in_ready. alu_ctrl, op_a and op_b are latched on acceptance and ignored afterwards.
- IDLE, accept, non-shift op: compute and register result; go to DONE.
- IDLE, accept, shift op with amount 0: result = op_a; go to DONE.
- IDLE, accept, shift op with amount k > 0: load op_a into the working register and k into the counter; go to SHIFT.
- SHIFT: each cycle shift the working register by 1 and decrement the counter.
  - SLL fills with 0; SRL fills with 0; SRA fills with the sign bit.
  - When the counter reaches 1 on that step, go to DONE.
- DONE: out_valid = 1; hold result and zero stable until out_ready. On out_ready go to IDLE.
- ADD/SUB wrap modulo 2^WIDTH; no overflow or carry output.
- SLT: signed compare, result = {WIDTH-1 zeros, a<b}. SLTU: unsigned compare, same result format.
- Undefined codes (1010–1111) execute as ADD.
- zero is computed from the final result value in the same cycle result is written.

## Timing
- Reset values: in_ready 1, out_valid 0, result 0, zero 0, state IDLE, counter 0.
- Reset mid-operation (SHIFT or DONE) discards the operation and returns to IDLE on the next edge.
- Latency, acceptance edge to out_valid high:
  - non-shift ops and zero-amount shifts: 1 cycle
  - shift by k: k+1 cycles; maximum WIDTH cycles (k = WIDTH-1)
- in_ready is low in SHIFT and DONE. No pass-through: the next acceptance happens no earlier than the cycle after the out_ready handshake. Peak throughput is one op per 2 cycles.
- out_ready asserted before out_valid has no effect.
- in_valid held high while busy has no effect; the request waits.

## Configuration
- BARREL_SHIFT_EN defined: shifts are computed combinationally in IDLE and go straight to DONE with 1-cycle latency for every op. The SHIFT state and counter are not built.
- BARREL_SHIFT_EN undefined: iterative shifting as described above.
- Handshake, reset behaviour and results are identical in both builds.

## Test plan
- After reset: in_ready=1, out_valid=0, result=0, zero=0 → ADD 5+7 gives result 12, zero 0, out_valid exactly 1 cycle after acceptance.
- SUB 0x10−0x10 → result 0, zero 1. SLT 0xFFFFFFFF vs 1 → 1. SLTU with the same operands → 0. Code 1111 with 3, 4 → 7.
- SRA 0x80000000 by 4 → 0xF8000000 after 5 cycles (1 cycle with BARREL_SHIFT_EN). SRL of the same → 0x08000000. SLL 1 by 31 → 0x80000000 after 32 cycles.
- Shift amount 0 with op_b=0x20 (amount bits = 0) → result = op_a, latency 1.
- out_ready held low for 3 cycles in DONE → result stable and in_ready=0 throughout; a second op presented with in_valid high is accepted only after the handshake.
- rst asserted in the middle of a 20-step shift → next cycle IDLE, out_valid 0, result 0; no stale output appears afterwards.
